led_blink_arbiter: RTL and testbench

Shares the single board LED between several status requesters. Each requester asks for a numbered burst of blinks. The block grants the LED round-robin and sequences the burst: on/off phases, an inter-burst gap, then a completion pulse. It sits between the on-chip status logic and the top-level LED port, in place of a direct LED assignment, and runs from the board CLOCK net.

---
 rtl/led_blink_arbiter.sv | 161 ++++++++++++++++
 tb/tb_led_blink_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - round-robin owner of the board LED; sequences blink bursts per requester
module led_blink_arbiter #(
    parameter int TICK_DIV  = 4,
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 8,
    parameter int GAP_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   blinks,
    input  logic [CNT_W-1:0]     on_ticks,
    input  logic [CNT_W-1:0]     off_ticks,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 done,
    output logic                 led
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);
    localparam int BASE_W = (CNT_W > GAP_W) ? CNT_W : GAP_W;
    localparam int PH_W   = BASE_W + $clog2(TICK_DIV + 1);

    localparam logic [PH_W-1:0] TD       = PH_W'(TICK_DIV);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS * TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP,
        S_FIN
    } state_t;

    state_t            state;
    logic [PH_W-1:0]   cyc;
    logic [PH_W-1:0]   on_last;
    logic [PH_W-1:0]   off_last;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  owner;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    cand;
    logic [3:0]        win_blinks;
    logic [CNT_W-1:0]  on_eff;
    logic [CNT_W-1:0]  off_eff;
    logic [PH_W-1:0]   on_last_nxt;
    logic [PH_W-1:0]   off_last_nxt;

    // Search starts one past the previous owner so every pending requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_blinks   = blinks[{win_idx, 2'b00} +: 4];
        on_eff       = (on_ticks  == '0) ? CNT_W'(1) : on_ticks;
        off_eff      = (off_ticks == '0) ? CNT_W'(1) : off_ticks;
        on_last_nxt  = PH_W'(on_eff)  * TD - PH_W'(1);
        off_last_nxt = PH_W'(off_eff) * TD - PH_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cyc        <= '0;
            cnt        <= '0;
            on_last    <= '0;
            off_last   <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            grant      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            led        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        busy     <= 1'b1;
                        owner    <= win_idx;
                        cnt      <= win_blinks;
                        on_last  <= on_last_nxt;
                        off_last <= off_last_nxt;
                        cyc      <= '0;
                        if (win_blinks != 4'd0) begin
                            state <= S_ON;
                            led   <= 1'b1;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (cyc == on_last) begin
                        cyc   <= '0;
                        led   <= 1'b0;
                        state <= S_OFF;
                    end else begin
                        cyc <= cyc + PH_W'(1);
                    end
                end
                S_OFF: begin
                    if (cyc == off_last) begin
                        cyc <= '0;
                        cnt <= cnt - 4'd1;
                        // cnt is the count before this decrement, so 1 means the last blink just ended
                        if (cnt != 4'd1) begin
                            state <= S_ON;
                            led   <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end else begin
                        cyc <= cyc + PH_W'(1);
                    end
                end
                S_GAP: begin
                    if (cyc == GAP_LAST) begin
                        cyc   <= '0;
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        cyc <= cyc + PH_W'(1);
                    end
                end
                S_FIN: begin
                    state      <= S_IDLE;
                    grant      <= '0;
                    busy       <= 1'b0;
                    last_grant <= owner;
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb/tb_led_blink_arbiter.sv - directed scoreboard bench for led_blink_arbiter
module tb_led_blink_arbiter;

    localparam int TD  = 4;
    localparam int NR  = 4;
    localparam int CW  = 8;
    localparam int GAP = 2;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [4*NR-1:0] blinks;
    logic [CW-1:0]   on_ticks;
    logic [CW-1:0]   off_ticks;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            done;
    logic            led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NR-1:0] grant;
        int            len;
        int            hi;
        int            first;
        int            wait_cyc;
    } exp_t;

    exp_t sb[$];

    led_blink_arbiter #(
        .TICK_DIV (TD),
        .N_REQ    (NR),
        .CNT_W    (CW),
        .GAP_TICKS(GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .blinks   (blinks),
        .on_ticks (on_ticks),
        .off_ticks(off_ticks),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected burst shape from the documented timing formula; len excludes the FIN cycle.
    function automatic exp_t mk(input logic [NR-1:0] g, input int b, input int on, input int off,
                                input int w);
        exp_t e;
        int   on_e;
        int   off_e;
        on_e       = (on == 0) ? 1 : on;
        off_e      = (off == 0) ? 1 : off;
        e.grant    = g;
        e.len      = (b == 0) ? 0 : (b * (on_e + off_e) + GAP) * TD;
        e.hi       = b * on_e * TD;
        e.first    = (b == 0) ? 0 : on_e * TD;
        e.wait_cyc = w;
        return e;
    endfunction

    task automatic pulse_req(input logic [NR-1:0] m);
        req = m;
        @(negedge clk);
        req = '0;
    endtask

    task automatic observe_burst(input int mid_at);
        exp_t e;
        int   n;
        int   len;
        int   hi;
        int   first;
        bit   in_first;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        n = 0;
        while (grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (e.wait_cyc >= 0) check("grant_wait", n, e.wait_cyc);
        check("grant", grant, e.grant);
        check("busy", busy, 1);
        len      = 0;
        hi       = 0;
        first    = 0;
        in_first = 1'b1;
        while (!done && len < 1000) begin
            if (led) begin
                hi++;
                if (in_first) first++;
            end else begin
                in_first = 1'b0;
            end
            if (len == mid_at) begin
                req          = '0;
                blinks[3:0]  = 4'd1;
            end
            @(negedge clk);
            len++;
        end
        check("burst_len", len, e.len);
        check("led_high", hi, e.hi);
        check("first_on", first, e.first);
        check("fin_led", led, 0);
        check("fin_grant", grant, e.grant);
        @(negedge clk);
        check("idle_grant", grant, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        blinks    = '0;
        on_ticks  = '0;
        off_ticks = '0;
        #1;
        check("rst_led", led, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all four requesting
        blinks    = {4'd1, 4'd1, 4'd1, 4'd1};
        on_ticks  = 8'd1;
        off_ticks = 8'd1;
        req       = 4'b1111;
        sb.push_back(mk(4'b0001, 1, 1, 1, 1));
        sb.push_back(mk(4'b0010, 1, 1, 1, 1));
        sb.push_back(mk(4'b0100, 1, 1, 1, 1));
        sb.push_back(mk(4'b1000, 1, 1, 1, 1));
        sb.push_back(mk(4'b0001, 1, 1, 1, -1));
        for (int i = 0; i < 4; i++) observe_burst(-1);
        pulse_req(4'b0001);
        observe_burst(-1);

        // Single two-blink burst for requester 1
        blinks[7:4] = 4'd2;
        on_ticks    = 8'd3;
        off_ticks   = 8'd2;
        sb.push_back(mk(4'b0010, 2, 3, 2, -1));
        pulse_req(4'b0010);
        observe_burst(-1);

        // Zero blink count
        blinks[11:8] = 4'd0;
        sb.push_back(mk(4'b0100, 0, 1, 1, -1));
        pulse_req(4'b0100);
        observe_burst(-1);

        // Zero on/off ticks act as one tick
        blinks[15:12] = 4'd1;
        on_ticks      = 8'd0;
        off_ticks     = 8'd0;
        sb.push_back(mk(4'b1000, 1, 0, 0, -1));
        pulse_req(4'b1000);
        observe_burst(-1);

        // Request dropped and count changed mid-burst
        blinks[3:0] = 4'd3;
        on_ticks    = 8'd1;
        off_ticks   = 8'd1;
        req         = 4'b0001;
        sb.push_back(mk(4'b0001, 3, 1, 1, 1));
        observe_burst(5);

        // Asynchronous reset during the second ON phase
        blinks[7:4] = 4'd3;
        on_ticks    = 8'd2;
        off_ticks   = 8'd2;
        pulse_req(4'b0010);
        begin
            int n;
            n = 0;
            while (grant == '0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("pre_rst_grant", grant, 4'b0010);
        repeat (18) @(negedge clk);
        check("pre_rst_led", led, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_led", led, 0);
        check("async_grant", grant, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        req          = 4'b0100;
        blinks[11:8] = 4'd1;
        on_ticks     = 8'd1;
        off_ticks    = 8'd1;
        sb.push_back(mk(4'b0100, 1, 1, 1, 1));
        observe_burst(-1);
        @(negedge clk);
        check("regrant", grant, 4'b0100);
        req = '0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
